// File: rtl/gray_pkg.sv
// Gray-code helpers shared by the encoder/decoder family and their benches.
// Functions operate on GRAY_MAX_WIDTH bits; narrower codes are zero-extended.
package gray_pkg;

    localparam int unsigned GRAY_MAX_WIDTH = 16;

    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero-extended upper bits stay zero.
    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g);
        logic [GRAY_MAX_WIDTH-1:0] r;
        r[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            r[i] = r[i+1] ^ g[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_to_gray_comb.sv
// Combinational WIDTH-bit binary-to-Gray encoder.
// Zero latency, no flow control.
module bin_to_gray_comb #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/bin_to_gray_counter.sv
// Registered binary up/down counter with Gray-coded copy and rollover pulse.
// One-cycle latency from inputs to all outputs; no backpressure, load > en > hold.
module bin_to_gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Out-of-range widths fail elaboration on the missing module.
    if (WIDTH < 2 || WIDTH > GRAY_MAX_WIDTH) begin : g_bad_width
        illegal_width_parameter u_bad ();
    end

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_val;
        end else if (en) begin
            if (up) begin
                bin_d  = bin_q + ONE;
                wrap_d = &bin_q;
            end else begin
                bin_d  = bin_q - ONE;
                wrap_d = ~|bin_q;
            end
        end
    end

    // Encoding the next value keeps gray and bin consistent in the same cycle.
    bin_to_gray_comb #(
        .WIDTH (WIDTH)
    ) u_enc (
        .bin_i  (bin_d),
        .gray_o (gray_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_bin_to_gray_counter.sv
// Directed and random bench for bin_to_gray_counter at WIDTH=4 and WIDTH=8.
module tb_bin_to_gray_counter;
    import gray_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4 = 1'b1, en4 = 1'b0, up4 = 1'b1, load4 = 1'b0;
    logic [3:0] load_val4 = '0;
    logic [3:0] bin4, gray4;
    logic       wrap4;

    logic       rst8 = 1'b1, en8 = 1'b0, up8 = 1'b1, load8 = 1'b0;
    logic [7:0] load_val8 = '0;
    logic [7:0] bin8, gray8;
    logic       wrap8;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Hand-written 4-bit Gray table indexed by binary value.
    logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                  4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                  4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                  4'b1010, 4'b1011, 4'b1001, 4'b1000};

    bin_to_gray_counter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .en(en4), .up(up4), .load(load4),
        .load_val(load_val4), .bin(bin4), .gray(gray4), .wrap(wrap4)
    );

    bin_to_gray_counter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .en(en8), .up(up8), .load(load8),
        .load_val(load_val8), .bin(bin8), .gray(gray8), .wrap(wrap8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst4 = 1'b1; en4 = 1'b1; load4 = 1'b1; load_val4 = 4'd5;
        step();
        total_cnt++;
        if ({bin4, gray4, wrap4} !== 9'b0000_0000_0) begin
            $display("FAIL reset_hold: got bin=%b gray=%b wrap=%b want 0000 0000 0", bin4, gray4, wrap4);
        end else pass_cnt++;
        load4 = 1'b0; en4 = 1'b0;
        rst4 = 1'b0;
        step();
        total_cnt++;
        if ({bin4, gray4, wrap4} !== 9'b0000_0000_0) begin
            $display("FAIL reset_idle: got bin=%b gray=%b wrap=%b want 0000 0000 0", bin4, gray4, wrap4);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid_count();
        en4 = 1'b1; up4 = 1'b1;
        repeat (9) step();
        total_cnt++;
        if ({bin4, gray4} !== {4'd9, 4'b1101}) begin
            $display("FAIL count_to_9: got bin=%b gray=%b want 1001 1101", bin4, gray4);
        end else pass_cnt++;
        #2 rst4 = 1'b1;
        #1;
        total_cnt++;
        if ({bin4, gray4, wrap4} !== 9'b0000_0000_0) begin
            $display("FAIL async_reset: got bin=%b gray=%b wrap=%b want 0000 0000 0", bin4, gray4, wrap4);
        end else pass_cnt++;
        @(negedge clk);
        rst4 = 1'b0;
        step();
        total_cnt++;
        if ({bin4, gray4, wrap4} !== {4'd1, 4'b0001, 1'b0}) begin
            $display("FAIL reset_release: got bin=%b gray=%b wrap=%b want 0001 0001 0", bin4, gray4, wrap4);
        end else pass_cnt++;
        en4 = 1'b0;
    endtask

    task automatic test_up_sweep();
        logic [3:0] eb;
        logic [3:0] prev;
        en4 = 1'b0; load4 = 1'b1; load_val4 = 4'd0;
        step();
        load4 = 1'b0; en4 = 1'b1; up4 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            prev = gray4;
            step();
            eb = 4'(i + 1);
            total_cnt++;
            if ({bin4, gray4, wrap4} !== {eb, gray_tab[eb], (eb == 4'd0)}) begin
                $display("FAIL up_sweep[%0d]: got bin=%b gray=%b wrap=%b want %b %b %b",
                         i, bin4, gray4, wrap4, eb, gray_tab[eb], (eb == 4'd0));
            end else pass_cnt++;
            total_cnt++;
            if ($countones(gray4 ^ prev) != 1) begin
                $display("FAIL up_flip[%0d]: got %0d bits changed want 1", i, $countones(gray4 ^ prev));
            end else pass_cnt++;
        end
        en4 = 1'b0;
    endtask

    task automatic test_down_wrap();
        logic [3:0] eb   [4] = '{4'd1, 4'd0, 4'd15, 4'd14};
        logic [3:0] eg   [4] = '{4'b0001, 4'b0000, 4'b1000, 4'b1001};
        logic       ew   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        load4 = 1'b1; load_val4 = 4'd1; en4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            load4 = 1'b0; en4 = 1'b1; up4 = 1'b0;
            total_cnt++;
            if ({bin4, gray4, wrap4} !== {eb[i], eg[i], ew[i]}) begin
                $display("FAIL down_wrap[%0d]: got bin=%b gray=%b wrap=%b want %b %b %b",
                         i, bin4, gray4, wrap4, eb[i], eg[i], ew[i]);
            end else pass_cnt++;
        end
        en4 = 1'b0;
    endtask

    task automatic test_load_priority();
        load4 = 1'b1; load_val4 = 4'd15; en4 = 1'b0;
        step();
        total_cnt++;
        if ({bin4, gray4, wrap4} !== {4'd15, 4'b1000, 1'b0}) begin
            $display("FAIL load_ones: got bin=%b gray=%b wrap=%b want 1111 1000 0", bin4, gray4, wrap4);
        end else pass_cnt++;
        load4 = 1'b1; load_val4 = 4'd0; en4 = 1'b1; up4 = 1'b1;
        step();
        total_cnt++;
        if ({bin4, gray4, wrap4} !== 9'b0000_0000_0) begin
            $display("FAIL load_over_en: got bin=%b gray=%b wrap=%b want 0000 0000 0", bin4, gray4, wrap4);
        end else pass_cnt++;
        load4 = 1'b0; en4 = 1'b0; load_val4 = 4'd7;
        for (int i = 0; i < 2; i++) begin
            step();
            total_cnt++;
            if ({bin4, gray4, wrap4} !== 9'b0000_0000_0) begin
                $display("FAIL load_hold[%0d]: got bin=%b gray=%b wrap=%b want 0000 0000 0", i, bin4, gray4, wrap4);
            end else pass_cnt++;
        end
    endtask

    task automatic test_dir_change_hold();
        logic [3:0] eb [4] = '{4'd6, 4'd5, 4'd5, 4'd5};
        logic [3:0] eg [4] = '{4'b0101, 4'b0111, 4'b0111, 4'b0111};
        logic       e  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       u  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        load4 = 1'b1; load_val4 = 4'd5; en4 = 1'b0;
        step();
        load4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en4 = e[i]; up4 = u[i];
            step();
            total_cnt++;
            if ({bin4, gray4, wrap4} !== {eb[i], eg[i], 1'b0}) begin
                $display("FAIL dir_hold[%0d]: got bin=%b gray=%b wrap=%b want %b %b 0",
                         i, bin4, gray4, wrap4, eb[i], eg[i]);
            end else pass_cnt++;
        end
        en4 = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] mb, nb, lv, prev;
        logic       mw, l, e, u;
        rst8 = 1'b0;
        mb = '0;
        for (int c = 0; c < 10000; c++) begin
            l  = ($urandom_range(0, 19) == 0);
            e  = ($urandom_range(0, 4) != 0);
            u  = 1'($urandom_range(0, 1));
            lv = 8'($urandom_range(0, 255));
            if (l) begin
                nb = lv; mw = 1'b0;
            end else if (e) begin
                nb = u ? mb + 8'd1 : mb - 8'd1;
                mw = u ? (mb == 8'hFF) : (mb == 8'h00);
            end else begin
                nb = mb; mw = 1'b0;
            end
            load8 = l; en8 = e; up8 = u; load_val8 = lv;
            prev = gray8;
            step();
            mb = nb;
            total_cnt++;
            if (bin8 !== mb) begin
                $display("FAIL rnd_bin[%0d]: got %h want %h", c, bin8, mb);
            end else pass_cnt++;
            total_cnt++;
            if (gray2bin(16'(gray8)) !== 16'(bin8)) begin
                $display("FAIL rnd_gray2bin[%0d]: got gray=%h for bin=%h", c, gray8, bin8);
            end else pass_cnt++;
            total_cnt++;
            if (wrap8 !== mw) begin
                $display("FAIL rnd_wrap[%0d]: got %b want %b", c, wrap8, mw);
            end else pass_cnt++;
            if (!l && e) begin
                total_cnt++;
                if ($countones(gray8 ^ prev) != 1) begin
                    $display("FAIL rnd_flip[%0d]: got %0d bits changed want 1", c, $countones(gray8 ^ prev));
                end else pass_cnt++;
            end
        end
        load8 = 1'b0; en8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_mid_count();
        test_up_sweep();
        test_down_wrap();
        test_load_priority();
        test_dir_change_hold();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
